// File: rtl/fib_step_sequencer_if.sv
// Command, engine and response signals of fib_step_sequencer.
// slave: sequencer side; master: requester/engine/consumer side.
interface fib_step_sequencer_if;
    localparam int unsigned DATA_W = 8;

    logic              req0_valid;
    logic              req1_valid;
    logic              req0_ready;
    logic              req1_ready;
    logic [DATA_W-1:0] req0_count;
    logic [DATA_W-1:0] req1_count;
    logic              req0_clr;
    logic              req1_clr;
    logic              eng_step;
    logic              eng_clr;
    logic [DATA_W-1:0] eng_out;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_id;
    logic              resp_ovf;

    modport slave (
        input  req0_valid, req1_valid, req0_count, req1_count, req0_clr, req1_clr,
        input  eng_out, resp_ready,
        output req0_ready, req1_ready, eng_step, eng_clr,
        output resp_valid, resp_data, resp_id, resp_ovf
    );

    modport master (
        output req0_valid, req1_valid, req0_count, req1_count, req0_clr, req1_clr,
        output eng_out, resp_ready,
        input  req0_ready, req1_ready, eng_step, eng_clr,
        input  resp_valid, resp_data, resp_id, resp_ovf
    );
endinterface

// File: rtl/fib_step_sequencer.sv
// Two-requester sequencer driving a shared step engine and returning one captured result per command.
// Optional wrap detection on resp_ovf is enabled by defining FIBSEQ_OVF_DETECT_EN.
module fib_step_sequencer (
    input  logic                 clk,
    input  logic                 rst,
    fib_step_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        RUN  = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               step_q, step_d;
    logic               eclr_q, eclr_d;
    logic               rvalid_q, rvalid_d;

    logic               grant_c;
    logic               accept_c;
    logic [CNT_W-1:0]   sel_count_c;
    logic               sel_clr_c;

    // Round-robin pick between simultaneous requesters; ready only while idle.
    always_comb begin
        grant_c = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_c = ptr_q;
        end else if (bus.req1_valid) begin
            grant_c = 1'b1;
        end
        accept_c    = (state_q == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
        sel_count_c = grant_c ? bus.req1_count : bus.req0_count;
        sel_clr_c   = grant_c ? bus.req1_clr   : bus.req0_clr;
    end

    assign bus.req0_ready = accept_c && !grant_c;
    assign bus.req1_ready = accept_c &&  grant_c;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    ptr_d = !grant_c;
                    cnt_d = sel_count_c;
                    id_d  = grant_c;
                    if (sel_clr_c) begin
                        state_d = CLR;
                    end else if (sel_count_c != CNT_W'(0)) begin
                        state_d = RUN;
                    end else begin
                        state_d = CAPT;
                    end
                end
            end
            CLR: begin
                state_d = (cnt_q != CNT_W'(0)) ? RUN : CAPT;
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                data_d  = bus.eng_out;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered copies of the state being entered.
        step_d   = (state_d == RUN);
        eclr_d   = (state_d == CLR);
        rvalid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            id_q     <= 1'b0;
            data_q   <= '0;
            step_q   <= 1'b0;
            eclr_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            data_q   <= data_d;
            step_q   <= step_d;
            eclr_q   <= eclr_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.eng_step   = step_q;
    assign bus.eng_clr    = eclr_q;
    assign bus.resp_valid = rvalid_q;
    assign bus.resp_data  = data_q;
    assign bus.resp_id    = id_q;

`ifdef FIBSEQ_OVF_DETECT_EN
    logic [DATA_W-1:0]  prev_q, prev_d;
    logic               seed_q, seed_d;
    logic               ovf_q, ovf_d;
    logic               wrap_c;

    // First RUN/CAPT sample seeds the history; later samples flag any decrease.
    always_comb begin
        prev_d = prev_q;
        seed_d = seed_q;
        wrap_c = 1'b0;
        if (accept_c) begin
            seed_d = 1'b0;
        end else if ((state_q == RUN) || (state_q == CAPT)) begin
            wrap_c = seed_q && (bus.eng_out < prev_q);
            prev_d = bus.eng_out;
            seed_d = 1'b1;
        end
        ovf_d = accept_c ? 1'b0 : (ovf_q || wrap_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            seed_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            seed_q <= seed_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.resp_ovf = ovf_q;
`else
    assign bus.resp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fib_step_sequencer.sv
// Directed and randomized checks of fib_step_sequencer against a Fibonacci engine
// model and an arithmetic reference of arbitration, results and latency.
module tb_fib_step_sequencer;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fib_step_sequencer_if bus ();

    fib_step_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side engine: clear gives 1, each step yields the next Fibonacci term mod 256.
    logic [7:0] eng_cur = 8'd1;
    logic [7:0] eng_prv = 8'd0;
    always @(posedge clk) begin
        if (bus.eng_clr) begin
            eng_cur <= 8'd1;
            eng_prv <= 8'd0;
        end else if (bus.eng_step) begin
            eng_cur <= 8'(eng_cur + eng_prv);
            eng_prv <= eng_cur;
        end
    end
    assign bus.eng_out = eng_cur;

    // Reference state
    int         m_ptr = 0;
    logic [7:0] m_cur = 8'd1;
    logic [7:0] m_prev = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input bit v0, input bit v1, input int c0, input int c1,
                           input bit k0, input bit k1, input int hold);
        int         win;
        int         cnt;
        bit         clr;
        int         n;
        int         steps;
        int         clrs;
        bit         both;
        bit         busy_rdy;
        bit         stable;
        logic [7:0] s;
        logic [7:0] nx;
        logic [7:0] ev;
        bit         eovf;

        win = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
        m_ptr = 1 - win;
        cnt = (win == 1) ? c1 : c0;
        clr = (win == 1) ? k1 : k0;
        if (clr) begin
            m_cur  = 8'd1;
            m_prev = 8'd0;
        end
        s    = m_cur;
        eovf = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            nx     = 8'(m_cur + m_prev);
            m_prev = m_cur;
            m_cur  = nx;
            if (m_cur < s) eovf = 1'b1;
            s = m_cur;
        end
        ev = m_cur;
`ifndef FIBSEQ_OVF_DETECT_EN
        eovf = 1'b0;
`endif

        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_count = 8'(c0);
        bus.req1_count = 8'(c1);
        bus.req0_clr   = k0;
        bus.req1_clr   = k1;
        bus.resp_ready = (hold == 0);
        #1;
        chk("ready0", 32'(bus.req0_ready), 32'(win == 0));
        chk("ready1", 32'(bus.req1_ready), 32'(win == 1));
        @(posedge clk); #1;
        if (win == 0) bus.req0_valid = 1'b0;
        else          bus.req1_valid = 1'b0;

        n = 1; steps = 0; clrs = 0; both = 1'b0; busy_rdy = 1'b0;
        while (!bus.resp_valid && n < 400) begin
            steps += 32'(bus.eng_step);
            clrs  += 32'(bus.eng_clr);
            both     |= bus.eng_step && bus.eng_clr;
            busy_rdy |= bus.req0_ready || bus.req1_ready;
            @(posedge clk); #1;
            n++;
        end
        chk("latency",    32'(n),            32'(cnt + 2 + 32'(clr)));
        chk("step_cycles",32'(steps),        32'(cnt));
        chk("clr_cycles", 32'(clrs),         32'(clr));
        chk("step_clr_overlap", 32'(both),   32'd0);
        chk("busy_ready", 32'(busy_rdy),     32'd0);
        chk("resp_data",  32'(bus.resp_data),32'(ev));
        chk("resp_id",    32'(bus.resp_id),  32'(win));
        chk("resp_ovf",   32'(bus.resp_ovf), 32'(eovf));

        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                stable &= bus.resp_valid && (bus.resp_data == ev) && (bus.resp_id == 1'(win))
                          && !bus.req0_ready && !bus.req1_ready;
            end
            chk("resp_hold", 32'(stable), 32'd1);
            bus.resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("resp_done", 32'(bus.resp_valid), 32'd0);
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        bit quiet;
        int r;

        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_count = 8'd0;
        bus.req1_count = 8'd0;
        bus.req0_clr   = 1'b0;
        bus.req1_clr   = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_eng_step",   32'(bus.eng_step),   32'd0);
        chk("rst_eng_clr",    32'(bus.eng_clr),    32'd0);
        chk("rst_resp_data",  32'(bus.resp_data),  32'd0);
        chk("rst_resp_id",    32'(bus.resp_id),    32'd0);
        chk("rst_resp_ovf",   32'(bus.resp_ovf),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Both valid back-to-back: grants alternate starting from requester 0
        repeat (4) run_cmd(1'b1, 1'b1, 1, 1, 1'b1, 1'b1, 0);

        // Single run with clear: 8 after 5 steps
        run_cmd(1'b1, 1'b0, 5, 0, 1'b1, 1'b0, 0);

        // Zero-count without clear returns the unchanged engine value
        run_cmd(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 0);

        // Consumer stalls for 10 cycles
        run_cmd(1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 10);

        // Wrap boundary: 377 mod 256 and 233
        run_cmd(1'b1, 1'b0, 13, 0, 1'b1, 1'b0, 0);
        run_cmd(1'b0, 1'b1, 0, 12, 1'b0, 1'b1, 0);

        // Reset in the third RUN cycle of a long command
        bus.req0_valid = 1'b1;
        bus.req0_count = 8'd20;
        bus.req0_clr   = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_step", 32'(bus.eng_step), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_eng_step",   32'(bus.eng_step),   32'd0);
        chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("arst_resp_data",  32'(bus.resp_data),  32'd0);
        chk("arst_resp_id",    32'(bus.resp_id),    32'd0);
        chk("arst_resp_ovf",   32'(bus.resp_ovf),   32'd0);
        chk("arst_eng_clr",    32'(bus.eng_clr),    32'd0);
        #3 rst = 1'b0;
        m_ptr = 0;
        quiet = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
            quiet &= !bus.resp_valid && !bus.eng_step && !bus.eng_clr;
        end
        chk("no_resp_after_rst", 32'(quiet), 32'd1);
        bus.resp_ready = 1'b0;
        run_cmd(1'b1, 1'b1, 3, 4, 1'b1, 1'b1, 0);

        // Randomized commands
        for (int k = 0; k < 24; k++) begin
            r = int'($urandom_range(1, 3));
            run_cmd(r[0], r[1], int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fib_step_sequencer.md
FIB_STEP_SEQUENCER -- requirements
Module: fib_step_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-003 SHALL have ports req0_valid / req1_valid, input, 1 bit each, command offered by requester 0 / 1.
REQ-004 SHALL have ports req0_ready / req1_ready, output, 1 bit each, command accepted this cycle.
REQ-005 SHALL have ports req0_count / req1_count, input, 8 bits each, number of engine steps requested.
REQ-006 SHALL have ports req0_clr / req1_clr, input, 1 bit each, restart the engine before stepping.
REQ-007 SHALL have port eng_step, output, 1 bit, advance the shared step engine at the next edge.
REQ-008 SHALL have port eng_clr, output, 1 bit, return the engine to its initial state at the next edge.
REQ-009 SHALL have port eng_out, input, 8 bits, current engine output value.
REQ-010 SHALL have ports resp_valid (output, 1 bit) and resp_ready (input, 1 bit), response handshake.
REQ-011 SHALL have port resp_data, output, 8 bits, captured engine output.
REQ-012 SHALL have port resp_id, output, 1 bit, index of the requester being answered.
REQ-013 SHALL have port resp_ovf, output, 1 bit, wrap detected during the run.

Function
REQ-014 SHALL implement the states IDLE, CLR, RUN, CAPT and RESP.
REQ-015 In IDLE, SHALL assert ready only to the winning valid requester; all other ready outputs SHALL be 0.
- Both requesters valid: winner = priority pointer.
- One requester valid: that requester wins.
REQ-016 SHALL set the priority pointer to 0 on reset and, on each accept, to the non-granted index.
REQ-017 On accept, SHALL latch count, clr and id, then go to CLR if clr=1, else to RUN if count≠0, else to CAPT.
REQ-018 In CLR, SHALL hold eng_clr=1 for exactly one cycle, then go to RUN if count≠0, else to CAPT.
REQ-019 In RUN, SHALL hold eng_step=1 for exactly count consecutive cycles, using a down-counter, then go to CAPT.
REQ-020 In CAPT, SHALL hold eng_step=0 and load resp_data←eng_out at the cycle-ending edge, then go to RESP.
REQ-021 In RESP, SHALL hold resp_valid=1 with resp_data, resp_id and resp_ovf stable; on resp_valid&resp_ready, SHALL go to IDLE.
REQ-022 SHALL NOT accept a new command in any state other than IDLE, so no pipelining occurs.
REQ-023 Latency from the accept edge to resp_valid=1 SHALL be count+2 cycles, plus 1 cycle when clr=1.
REQ-024 SHALL assert eng_step and eng_clr only in RUN and CLR respectively, never simultaneously.
REQ-025 A requester that deasserts valid while not granted SHALL have no effect.

Reset
REQ-026 On rst=1, asynchronously and at any state, SHALL force the following:
- state=IDLE, pointer=0, counter=0;
- resp_data=0, resp_id=0, resp_ovf=0;
- resp_valid=0, eng_step=0, eng_clr=0.
REQ-027 Reset during RUN SHALL abandon the command, with no response issued.

Configuration
REQ-028 The macro FIBSEQ_OVF_DETECT_EN SHALL enable overflow detection.
- Defined: resp_ovf SHALL be set when any eng_out sample taken during RUN or CAPT is less than the previous sample from the same command. The previous-sample register is seeded from eng_out on entry to RUN/CAPT. resp_ovf is cleared on accept.
- Undefined: resp_ovf SHALL be constant 0, and no comparator or sample register SHALL be synthesized.

Verification
Bench engine model: eng_clr gives eng_out=1; each step gives the next term of 1,1,2,3,5,8,13,… mod 256.
REQ-029 req0 {count=5, clr=1}, resp_ready=1 -> eng_clr pulses 1 cycle; eng_step is high 5 cycles; resp_data=8, resp_id=0; resp_valid appears 8 cycles after accept.
REQ-030 req0 and req1 both valid, each {count=1, clr=1}, repeated back-to-back -> grants alternate 0,1,0,1; no overlap of eng_step.
REQ-031 req1 {count=0, clr=0} after the previous run -> eng_step is never asserted; resp_data equals the unchanged eng_out; latency is 2 cycles.
REQ-032 resp_ready held 0 for 10 cycles in RESP -> resp_valid, resp_data and resp_id are stable; req*_ready stays 0.
REQ-033 rst pulsed in cycle 3 of a count=20 RUN -> all outputs return to 0 immediately; no response follows; the next command is served normally.
REQ-034 With FIBSEQ_OVF_DETECT_EN defined, {count=13, clr=1} -> resp_data=121 (377 mod 256) and resp_ovf=1; with count=12 -> resp_data=233 and resp_ovf=0.
